// File: rtl/tl_ul_src_arbiter.sv
// rtl/tl_ul_src_arbiter.sv - two-client TL-UL source arbiter; optional watchdog under TL_ARB_WATCHDOG_EN
module tl_ul_src_arbiter #(
    parameter int MAX_INFLIGHT = 2,
    parameter int WDOG_CYCLES  = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        c0_a_valid,
    output logic        c0_a_ready,
    input  logic [2:0]  c0_a_opcode,
    input  logic [2:0]  c0_a_param,
    input  logic [3:0]  c0_a_size,
    input  logic [31:0] c0_a_address,
    input  logic [3:0]  c0_a_mask,
    input  logic [31:0] c0_a_data,
    output logic        c0_d_valid,
    input  logic        c0_d_ready,
    output logic [2:0]  c0_d_opcode,
    output logic [3:0]  c0_d_size,
    output logic [31:0] c0_d_data,
    output logic        c0_d_denied,
    output logic        c0_d_corrupt,
    input  logic        c1_a_valid,
    output logic        c1_a_ready,
    input  logic [2:0]  c1_a_opcode,
    input  logic [2:0]  c1_a_param,
    input  logic [3:0]  c1_a_size,
    input  logic [31:0] c1_a_address,
    input  logic [3:0]  c1_a_mask,
    input  logic [31:0] c1_a_data,
    output logic        c1_d_valid,
    input  logic        c1_d_ready,
    output logic [2:0]  c1_d_opcode,
    output logic [3:0]  c1_d_size,
    output logic [31:0] c1_d_data,
    output logic        c1_d_denied,
    output logic        c1_d_corrupt,
    output logic        m_a_valid,
    input  logic        m_a_ready,
    output logic [2:0]  m_a_opcode,
    output logic [2:0]  m_a_param,
    output logic [3:0]  m_a_size,
    output logic        m_a_source,
    output logic [31:0] m_a_address,
    output logic [3:0]  m_a_mask,
    output logic [31:0] m_a_data,
    input  logic        m_d_valid,
    output logic        m_d_ready,
    input  logic [2:0]  m_d_opcode,
    input  logic [3:0]  m_d_size,
    input  logic        m_d_source,
    input  logic [31:0] m_d_data,
    input  logic        m_d_denied,
    input  logic        m_d_corrupt,
    output logic        wdog_err
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

    logic          rr_q, rr_d;
    logic          hold_q, hold_d;
    logic          hold_idx_q, hold_idx_d;
    logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic          elig0, elig1, gnt_valid, gnt_idx;
    logic          a_fire, d_fire, inc0, inc1, dec0, dec1;

    assign elig0 = c0_a_valid && (cnt0_q != CNT_MAX);
    assign elig1 = c1_a_valid && (cnt1_q != CNT_MAX);

    // Grant choice uses only registered state and client valids, never m_a_ready
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
        if (reset) begin
            if (hold_q) begin
                gnt_valid = 1'b1;
                gnt_idx   = hold_idx_q;
            end else if (elig0 && elig1) begin
                gnt_valid = 1'b1;
                gnt_idx   = ~rr_q;
            end else if (elig0 || elig1) begin
                gnt_valid = 1'b1;
                gnt_idx   = elig1;
            end
        end
    end

    // Forward the granted client's A beat, tagging it with the client index
    always_comb begin
        m_a_valid   = gnt_valid;
        m_a_source  = gnt_idx;
        m_a_opcode  = '0;
        m_a_param   = '0;
        m_a_size    = '0;
        m_a_address = '0;
        m_a_mask    = '0;
        m_a_data    = '0;
        c0_a_ready  = 1'b0;
        c1_a_ready  = 1'b0;
        if (gnt_valid && !gnt_idx) begin
            m_a_opcode  = c0_a_opcode;
            m_a_param   = c0_a_param;
            m_a_size    = c0_a_size;
            m_a_address = c0_a_address;
            m_a_mask    = c0_a_mask;
            m_a_data    = c0_a_data;
            c0_a_ready  = m_a_ready;
        end else if (gnt_valid) begin
            m_a_opcode  = c1_a_opcode;
            m_a_param   = c1_a_param;
            m_a_size    = c1_a_size;
            m_a_address = c1_a_address;
            m_a_mask    = c1_a_mask;
            m_a_data    = c1_a_data;
            c1_a_ready  = m_a_ready;
        end
    end

    // Steer the D beat to the client named by d_source; the other client sees nothing
    always_comb begin
        c0_d_valid   = 1'b0;
        c0_d_opcode  = '0;
        c0_d_size    = '0;
        c0_d_data    = '0;
        c0_d_denied  = 1'b0;
        c0_d_corrupt = 1'b0;
        c1_d_valid   = 1'b0;
        c1_d_opcode  = '0;
        c1_d_size    = '0;
        c1_d_data    = '0;
        c1_d_denied  = 1'b0;
        c1_d_corrupt = 1'b0;
        m_d_ready    = 1'b0;
        if (reset && !m_d_source) begin
            c0_d_valid   = m_d_valid;
            c0_d_opcode  = m_d_opcode;
            c0_d_size    = m_d_size;
            c0_d_data    = m_d_data;
            c0_d_denied  = m_d_denied;
            c0_d_corrupt = m_d_corrupt;
            m_d_ready    = c0_d_ready;
        end else if (reset) begin
            c1_d_valid   = m_d_valid;
            c1_d_opcode  = m_d_opcode;
            c1_d_size    = m_d_size;
            c1_d_data    = m_d_data;
            c1_d_denied  = m_d_denied;
            c1_d_corrupt = m_d_corrupt;
            m_d_ready    = c1_d_ready;
        end
    end

    assign a_fire = gnt_valid && m_a_ready;
    assign d_fire = m_d_valid && m_d_ready;
    assign inc0   = a_fire && !gnt_idx;
    assign inc1   = a_fire && gnt_idx;
    assign dec0   = d_fire && !m_d_source;
    assign dec1   = d_fire && m_d_source;

    // Next state: lock a stalled grant, rotate priority on fire, track outstanding counts
    always_comb begin
        rr_d       = rr_q;
        hold_d     = hold_q;
        hold_idx_d = hold_idx_q;
        if (a_fire) begin
            rr_d   = gnt_idx;
            hold_d = 1'b0;
        end else if (gnt_valid) begin
            hold_d     = 1'b1;
            hold_idx_d = gnt_idx;
        end
        cnt0_d = cnt0_q;
        if (inc0 && !dec0)
            cnt0_d = cnt0_q + CW'(1);
        else if (dec0 && !inc0 && cnt0_q != '0)
            cnt0_d = cnt0_q - CW'(1);
        cnt1_d = cnt1_q;
        if (inc1 && !dec1)
            cnt1_d = cnt1_q + CW'(1);
        else if (dec1 && !inc1 && cnt1_q != '0)
            cnt1_d = cnt1_q - CW'(1);
    end

    // Arbiter state registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_q       <= 1'b1;
            hold_q     <= 1'b0;
            hold_idx_q <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            rr_q       <= rr_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end

`ifdef TL_ARB_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_CYCLES);

    logic [WW-1:0] wdog_q, wdog_d;
    logic          err_q, err_d;
    logic          busy;

    assign busy = (cnt0_q != '0) || (cnt1_q != '0);

    // Count idle cycles with requests outstanding; saturate at the limit
    always_comb begin
        wdog_d = wdog_q;
        if (d_fire || !busy)
            wdog_d = '0;
        else if (wdog_q != WDOG_MAX)
            wdog_d = wdog_q + WW'(1);
        err_d = err_q || (wdog_q == WDOG_MAX);
    end

    // Watchdog counter and sticky error flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign wdog_err = err_q;
`else
    logic unused_wdog_cfg;
    assign unused_wdog_cfg = ^WDOG_CYCLES;
    assign wdog_err        = 1'b0;
`endif

endmodule
